// File: rtl/ycbcr_pkg.sv
// ycbcr_pkg: pixel field offsets, mask/overlay colours, FSM states and coordinate width helper
package ycbcr_pkg;
  localparam int Y_LSB  = 16;
  localparam int CB_LSB = 8;
  localparam int CR_LSB = 0;
  localparam logic [23:0] MASK_WHITE    = 24'hFF8080;
  localparam logic [23:0] MASK_BLACK    = 24'h008080;
  localparam logic [23:0] OVERLAY_GREEN = 24'h952B15;
  typedef enum logic {WAIT_VS, ACCUM} bbox_state_t;
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [7:0] cb_of(input logic [23:0] p);
    return p[CB_LSB +: 8];
  endfunction
  function automatic logic [7:0] cr_of(input logic [23:0] p);
    return p[CR_LSB +: 8];
  endfunction
endpackage

// File: rtl/video_xy_counter.sv
// video_xy_counter: de/vsync edge detect with saturating pixel X and line Y counters
module video_xy_counter
  import ycbcr_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int XW = coord_w(H_ACTIVE),
  parameter int YW = coord_w(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de,
  input  logic          vsync,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          vs_rise
);
  logic de_q, vs_q, de_fall;
  assign vs_rise = vsync & ~vs_q;
  assign de_fall = ~de & de_q;
  // x/y hold the coordinate of the pixel currently presented on de
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= 1'b0;
      vs_q <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      de_q <= de;
      vs_q <= vsync;
      x    <= de ? ((x == XW'(H_ACTIVE - 1)) ? x : x + 1'b1) : '0;
      y    <= vs_rise ? '0 : de_fall ? ((y == YW'(V_ACTIVE - 1)) ? y : y + 1'b1) : y;
    end
  end
endmodule

// File: rtl/ycbcr_bbox_detect.sv
// ycbcr_bbox_detect: Cb/Cr window mask, per-frame bbox/hit count, 2-cycle video path; BBOX_OVERLAY_EN adds bbox outline
module ycbcr_bbox_detect
  import ycbcr_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int CNT_W = 21,
  localparam int XW = coord_w(H_ACTIVE),
  localparam int YW = coord_w(V_ACTIVE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [23:0]      pixel_in,
  input  logic [7:0]       cb_min,
  input  logic [7:0]       cb_max,
  input  logic [7:0]       cr_min,
  input  logic [7:0]       cr_max,
  input  logic [CNT_W-1:0] min_pixels,
  input  logic             mask_view,
  output logic             de_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [23:0]      pixel_out,
  output logic [XW-1:0]    bbox_x_min,
  output logic [XW-1:0]    bbox_x_max,
  output logic [YW-1:0]    bbox_y_min,
  output logic [YW-1:0]    bbox_y_max,
  output logic [CNT_W-1:0] hit_count,
  output logic             bbox_valid,
  output logic             frame_done
);
  logic [7:0] cb_min_r, cb_max_r, cr_min_r, cr_max_r;
  logic [CNT_W-1:0] min_pix_r, acc_cnt;
  logic mask_r;
  logic [XW-1:0] x, acc_x_min, acc_x_max;
  logic [YW-1:0] y, acc_y_min, acc_y_max;
  logic vs_rise, hit, latch, acc_zero;
  logic [7:0] cb, cr;
  bbox_state_t state;
  logic de1, hs1, vs1, hit1, mask1;
  logic [23:0] pix1, pix_mux, pix_next;

  video_xy_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_xy (
    .clk     (clk),
    .rst_n   (rst_n),
    .de      (de_in),
    .vsync   (vsync_in),
    .x       (x),
    .y       (y),
    .vs_rise (vs_rise)
  );

  assign cb       = cb_of(pixel_in);
  assign cr       = cr_of(pixel_in);
  assign hit      = de_in && cb >= cb_min_r && cb <= cb_max_r && cr >= cr_min_r && cr <= cr_max_r;
  assign latch    = vs_rise && state == ACCUM;
  assign acc_zero = acc_cnt == '0;

  // The vsync edge cycle re-inits the accumulators, so a de pixel there counts toward no frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_VS;
      cb_min_r   <= '0;
      cb_max_r   <= '0;
      cr_min_r   <= '0;
      cr_max_r   <= '0;
      min_pix_r  <= '0;
      mask_r     <= 1'b0;
      acc_x_min  <= '1;
      acc_x_max  <= '0;
      acc_y_min  <= '1;
      acc_y_max  <= '0;
      acc_cnt    <= '0;
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
      hit_count  <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= latch;
      if (vs_rise) begin
        state     <= ACCUM;
        cb_min_r  <= cb_min;
        cb_max_r  <= cb_max;
        cr_min_r  <= cr_min;
        cr_max_r  <= cr_max;
        min_pix_r <= min_pixels;
        mask_r    <= mask_view;
        acc_x_min <= '1;
        acc_x_max <= '0;
        acc_y_min <= '1;
        acc_y_max <= '0;
        acc_cnt   <= '0;
      end else if (hit && state == ACCUM) begin
        acc_x_min <= (x < acc_x_min) ? x : acc_x_min;
        acc_x_max <= (x > acc_x_max) ? x : acc_x_max;
        acc_y_min <= (y < acc_y_min) ? y : acc_y_min;
        acc_y_max <= (y > acc_y_max) ? y : acc_y_max;
        acc_cnt   <= (&acc_cnt) ? acc_cnt : acc_cnt + 1'b1;
      end
      if (latch) begin
        bbox_x_min <= acc_zero ? '0 : acc_x_min;
        bbox_x_max <= acc_zero ? '0 : acc_x_max;
        bbox_y_min <= acc_zero ? '0 : acc_y_min;
        bbox_y_max <= acc_zero ? '0 : acc_y_max;
        hit_count  <= acc_cnt;
        bbox_valid <= !acc_zero && acc_cnt >= min_pix_r;
      end
    end
  end

  assign pix_mux = !de1 ? 24'h000000 : mask1 ? (hit1 ? MASK_WHITE : MASK_BLACK) : pix1;

`ifdef BBOX_OVERLAY_EN
  logic [XW-1:0] x1;
  logic [YW-1:0] y1;
  logic in_x, in_y, border;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= '0;
      y1 <= '0;
    end else begin
      x1 <= x;
      y1 <= y;
    end
  end
  assign in_x     = x1 >= bbox_x_min && x1 <= bbox_x_max;
  assign in_y     = y1 >= bbox_y_min && y1 <= bbox_y_max;
  assign border   = ((x1 == bbox_x_min || x1 == bbox_x_max) && in_y) ||
                    ((y1 == bbox_y_min || y1 == bbox_y_max) && in_x);
  assign pix_next = (de1 && bbox_valid && border) ? OVERLAY_GREEN : pix_mux;
`else
  assign pix_next = pix_mux;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de1       <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      hit1      <= 1'b0;
      mask1     <= 1'b0;
      pix1      <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      pixel_out <= '0;
    end else begin
      de1       <= de_in;
      hs1       <= hsync_in;
      vs1       <= vsync_in;
      hit1      <= hit;
      mask1     <= mask_r;
      pix1      <= pixel_in;
      de_out    <= de1;
      hsync_out <= hs1;
      vsync_out <= vs1;
      pixel_out <= pix_next;
    end
  end
endmodule

// File: tb/tb_ycbcr_bbox_detect.sv
// tb_ycbcr_bbox_detect: directed + randomized frames against a frame-level reference model
module tb_ycbcr_bbox_detect;
  localparam int H = 1280;
  localparam int V = 720;
  localparam int CW = 21;
  localparam logic [23:0] HIT = 24'h4EE146;
  localparam logic [23:0] BLK = 24'h008080;

  logic clk = 1'b0, rst_n = 1'b0;
  logic de_in = 0, hsync_in = 0, vsync_in = 0, mask_view = 0;
  logic [23:0] pixel_in = '0;
  logic [7:0] cb_min = 0, cb_max = 0, cr_min = 0, cr_max = 0;
  logic [CW-1:0] min_pixels = '0;
  logic de_out, hsync_out, vsync_out, bbox_valid, frame_done;
  logic [23:0] pixel_out;
  logic [10:0] bbox_x_min, bbox_x_max;
  logic [9:0] bbox_y_min, bbox_y_max;
  logic [CW-1:0] hit_count;
  logic [63:0] dut_bbox;

  ycbcr_bbox_detect dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_in(pixel_in), .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .min_pixels(min_pixels), .mask_view(mask_view), .de_out(de_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .pixel_out(pixel_out), .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
    .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max), .hit_count(hit_count),
    .bbox_valid(bbox_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  assign dut_bbox = {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, hit_count, bbox_valid};

  int checks = 0, errors = 0;
  logic [7:0] m_cbmin, m_cbmax, m_crmin, m_crmax;
  logic [CW-1:0] m_minpix;
  logic m_mask, m_armed, m_vs_prev, m_de_prev;
  int mx, my, a_xmin, a_xmax, a_ymin, a_ymax, a_cnt;
  int r_xmin, r_xmax, r_ymin, r_ymax, r_cnt;
  logic r_valid;
  logic [26:0] expq[$];
  logic [23:0] fr [8][1300];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_bbox();
    return {11'(r_xmin), 11'(r_xmax), 10'(r_ymin), 10'(r_ymax), 21'(r_cnt), r_valid};
  endfunction

  task automatic acc_init();
    a_xmin = 1 << 30; a_xmax = -1; a_ymin = 1 << 30; a_ymax = -1; a_cnt = 0;
  endtask

  task automatic model_reset();
    {m_cbmin, m_cbmax, m_crmin, m_crmax} = '0;
    m_minpix = '0; m_mask = 0; m_armed = 0; m_vs_prev = 0; m_de_prev = 0;
    mx = 0; my = 0;
    {r_xmin, r_xmax, r_ymin, r_ymax, r_cnt} = '0;
    r_valid = 0;
    acc_init();
    expq.delete();
  endtask

  // One pixel clock: predict the spec outputs for this input, then clock and compare
  task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] p);
    logic hit, rise, fd_exp;
    logic [23:0] ep;
    logic [26:0] e;
    de_in = de; hsync_in = hs; vsync_in = vs; pixel_in = p;
    rise = vs && !m_vs_prev;
    hit = de && p[15:8] >= m_cbmin && p[15:8] <= m_cbmax && p[7:0] >= m_crmin && p[7:0] <= m_crmax;
    ep = !de ? 24'h0 : m_mask ? (hit ? 24'hFF8080 : 24'h008080) : p;
`ifdef BBOX_OVERLAY_EN
    if (de && r_valid && ((((mx == r_xmin) || (mx == r_xmax)) && my >= r_ymin && my <= r_ymax) ||
        (((my == r_ymin) || (my == r_ymax)) && mx >= r_xmin && mx <= r_xmax)))
      ep = 24'h952B15;
`endif
    expq.push_back({de, hs, vs, ep});
    fd_exp = rise && m_armed;
    if (rise) begin
      if (m_armed) begin
        r_valid = a_cnt != 0 && a_cnt >= int'(m_minpix);
        r_cnt = a_cnt;
        r_xmin = a_cnt ? a_xmin : 0; r_xmax = a_cnt ? a_xmax : 0;
        r_ymin = a_cnt ? a_ymin : 0; r_ymax = a_cnt ? a_ymax : 0;
      end
      m_armed = 1;
      m_cbmin = cb_min; m_cbmax = cb_max; m_crmin = cr_min; m_crmax = cr_max;
      m_minpix = min_pixels; m_mask = mask_view;
      acc_init();
      my = 0;
    end else begin
      if (hit && m_armed) begin
        if (mx < a_xmin) a_xmin = mx;
        if (mx > a_xmax) a_xmax = mx;
        if (my < a_ymin) a_ymin = my;
        if (my > a_ymax) a_ymax = my;
        if (a_cnt < (1 << CW) - 1) a_cnt++;
      end
      if (!de && m_de_prev && my < V - 1) my++;
    end
    mx = de ? ((mx < H - 1) ? mx + 1 : mx) : 0;
    m_vs_prev = vs; m_de_prev = de;
    @(posedge clk); #1;
    if (expq.size() == 2) begin
      e = expq.pop_front();
      chk("video", 64'({de_out, hsync_out, vsync_out, pixel_out}), 64'(e));
    end
    chk("frame_done", 64'(frame_done), 64'(fd_exp));
    chk("bbox", dut_bbox, exp_bbox());
  endtask

  task automatic vsync_pulse();
    repeat (3) step(0, 0, 1, 24'h0);
    repeat (3) step(0, 0, 0, 24'h0);
  endtask

  task automatic lines(input int w, input int y0, input int y1);
    for (int y = y0; y < y1; y++) begin
      repeat (2) step(0, 1, 0, 24'h0);
      repeat (2) step(0, 0, 0, 24'h0);
      for (int x = 0; x < w; x++) step(1, 0, 0, fr[y][x]);
      repeat (3) step(0, 0, 0, 24'h0);
    end
  endtask

  task automatic fill(input logic [23:0] p);
    for (int y = 0; y < 8; y++) for (int x = 0; x < 1300; x++) fr[y][x] = p;
  endtask

  task automatic do_reset();
    de_in = 0; hsync_in = 0; vsync_in = 0; pixel_in = '0;
    rst_n = 0;
    #3;
    chk("reset_outputs", {4'(0), de_out, hsync_out, vsync_out, pixel_out, 1'b0, frame_done, 8'(0)} | 64'(|dut_bbox), 64'h0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    int w, h;
    logic [7:0] cbv, crv;
    model_reset();
    do_reset();
    // T1: full 64x4 frame of hits
    cb_min = 200; cb_max = 240; cr_min = 60; cr_max = 80; min_pixels = 1; mask_view = 0;
    fill(HIT);
    vsync_pulse();
    lines(64, 0, 4);
    vsync_pulse();
    chk("t1_full", dut_bbox, {11'd0, 11'd63, 10'd0, 10'd3, 21'd256, 1'b1});
    // T2/T3: single hit at (10,2), min_pixels 1 then 2
    fill(BLK); fr[2][10] = HIT;
    lines(64, 0, 4);
    min_pixels = 2;
    vsync_pulse();
    chk("t2_single", dut_bbox, {11'd10, 11'd10, 10'd2, 10'd2, 21'd1, 1'b1});
    lines(64, 0, 4);
    vsync_pulse();
    chk("t3_below_min", dut_bbox, {11'd10, 11'd10, 10'd2, 10'd2, 21'd1, 1'b0});
    // T4: no hits
    fill(BLK);
    lines(64, 0, 4);
    mask_view = 1;
    vsync_pulse();
    chk("t4_empty", dut_bbox, 64'h0);
    // T5: mask view, alternating hit/miss
    for (int x = 0; x < 16; x++) begin fr[0][x] = x[0] ? HIT : BLK; fr[1][x] = x[0] ? BLK : HIT; end
    lines(16, 0, 2);
    mask_view = 0; min_pixels = 1;
    vsync_pulse();
    chk("t5_mask_count", 64'(hit_count), 64'd16);
    // T6: cb_max changed mid-frame takes effect only at the next vsync
    fill(HIT);
    lines(32, 0, 2);
    cb_max = 100;
    lines(32, 2, 4);
    vsync_pulse();
    chk("t6_midframe", dut_bbox, {11'd0, 11'd31, 10'd0, 10'd3, 21'd128, 1'b1});
    lines(8, 0, 1);
    cb_max = 240;
    vsync_pulse();
    chk("t7_new_window", dut_bbox, 64'h0);
    // T8: oversized line saturates X at H_ACTIVE-1
    fill(BLK);
    for (int x = 1290; x < 1300; x++) fr[0][x] = HIT;
    lines(1300, 0, 1);
    vsync_pulse();
    chk("t8_x_sat", dut_bbox, {11'd1279, 11'd1279, 10'd0, 10'd0, 21'd10, 1'b1});
    // T9: bbox 5..9/1..2, then a frame that exercises the overlay
    fill(BLK);
    for (int y = 1; y < 3; y++) for (int x = 5; x < 10; x++) fr[y][x] = HIT;
    lines(16, 0, 4);
    mask_view = 1;
    vsync_pulse();
    chk("t9_rect", dut_bbox, {11'd5, 11'd9, 10'd1, 10'd2, 21'd10, 1'b1});
    for (int y = 0; y < 4; y++) for (int x = 0; x < 16; x++) fr[y][x] = (x % 3 == 0) ? HIT : BLK;
    lines(16, 0, 4);
    // Randomized frames; last one uses an inverted window
    for (int r = 0; r < 5; r++) begin
      cb_min = 8'($urandom_range(0, 200)); cb_max = cb_min + 8'($urandom_range(0, 55));
      cr_min = 8'($urandom_range(0, 200)); cr_max = cr_min + 8'($urandom_range(0, 55));
      if (r == 4) begin cbv = cb_min; cb_min = cb_max + 1; cb_max = cbv; end
      min_pixels = CW'($urandom_range(0, 20));
      mask_view = 1'($urandom);
      vsync_pulse();
      w = $urandom_range(8, 48); h = $urandom_range(1, 8);
      for (int y = 0; y < h; y++) for (int x = 0; x < w; x++) begin
        cbv = $urandom_range(0, 1) ? 8'($urandom_range(cb_min, cb_max)) : 8'($urandom);
        crv = $urandom_range(0, 1) ? 8'($urandom_range(cr_min, cr_max)) : 8'($urandom);
        fr[y][x] = {8'($urandom), cbv, crv};
      end
      lines(w, 0, h);
    end
    vsync_pulse();
    chk("rand_inverted", 64'(hit_count), 64'd0);
    // Reset mid-frame: outputs clear, first vsync only re-arms
    cb_min = 200; cb_max = 240; cr_min = 60; cr_max = 80; min_pixels = 1; mask_view = 0;
    fill(HIT);
    lines(8, 0, 1);
    repeat (4) step(1, 0, 0, HIT);
    do_reset();
    vsync_pulse();
    chk("rst_no_report", dut_bbox, 64'h0);
    lines(8, 0, 2);
    vsync_pulse();
    chk("rst_report", dut_bbox, {11'd0, 11'd7, 10'd0, 10'd1, 21'd16, 1'b1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
